// File: rtl/serial_frame_pkg.sv
// Shared constants for the serial frame transmitter: FSM state encoding and default width.
// Used by serial_frame_tx and tx_shifter.
package serial_frame_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/tx_shifter.sv
// Payload shift register plus bit counter for serial_frame_tx.
// The serial output is the register LSB, so it is a flop output with no input-to-output path.
module tx_shifter
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    input  logic             tail,
    output logic             ser,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    // One bit above the payload holds the trailing bit (parity or 0); zeros shift in behind it
    // so the line is low once the frame body has gone out.
    logic [WIDTH:0]  sh_q;
    logic [CW-1:0]   cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sh_q  <= {tail, data};
            cnt_q <= '0;
        end else if (shift) begin
            sh_q  <= {1'b0, sh_q[WIDTH:1]};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign ser  = sh_q[0];
    assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: LSB-first payload with start marker, busy and done pulse.
// Define SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             I,
    output logic             S,
    output logic             busy,
    output logic             done
);

    logic [1:0] state_q, state_d;
    logic       s_d, busy_d, done_d;
    logic       sh_load, sh_shift, last, tail;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    assign tail = ^data;
`else
    assign tail = 1'b0;
`endif

    tx_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk  (clk),
        .reset(reset),
        .load (sh_load),
        .shift(sh_shift),
        .data (data),
        .tail (tail),
        .ser  (I),
        .last (last)
    );

    always_comb begin
        state_d  = state_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        s_d      = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sh_load = 1'b1;
                    state_d = DATA;
                    s_d     = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DATA: begin
                sh_shift = 1'b1;
                busy_d   = 1'b1;
                if (last) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                sh_shift = 1'b1;
                busy_d   = 1'b1;
                done_d   = 1'b1;
                state_d  = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            S       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            S       <= s_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed, table-driven bench for serial_frame_tx (WIDTH=8 and WIDTH=2 instances).
// Follows SERIAL_FRAME_TX_PARITY_EN so it checks whichever build it is compiled with.
module tb_serial_frame_tx;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] data;
    logic       I, S, busy, done;
    logic       load2;
    logic [1:0] data2;
    logic       I2, S2, busy2, done2;

    int total = 0;
    int bad   = 0;

    serial_frame_tx #(.WIDTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .data (data),
        .I    (I),
        .S    (S),
        .busy (busy),
        .done (done)
    );

    serial_frame_tx #(.WIDTH(2)) dut2 (
        .clk  (clk),
        .reset(reset),
        .load (load2),
        .data (data2),
        .I    (I2),
        .S    (S2),
        .busy (busy2),
        .done (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // seq lists the expected line bits in transmit order, first bit in seq[7]
    typedef struct {
        logic [7:0] d;
        logic [7:0] seq;
        logic       par;
        int         inj;
        bit         hold;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got I/S/busy/done=%b want %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [7:0] d, input logic [7:0] seq,
                              input logic par, input int inj, input bit hold);
        load = 1'b1;
        data = d;
        step();
        data = ~d;
        if (!hold) load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_bit%0d", idx, i), {I, S, busy, done},
                {seq[7-i], (i == 0), 1'b1, 1'b0});
            if (i == inj) begin
                load = 1'b1;
                data = 8'h3C;
            end
            step();
            if (i == inj) begin
                load = 1'b0;
                data = ~d;
            end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        chk($sformatf("v%0d_parity", idx), {I, S, busy, done}, {par, 1'b0, 1'b1, 1'b0});
        step();
`else
        if (par === 1'bx) $display("note: parity unused");
`endif
        chk($sformatf("v%0d_done", idx), {I, S, busy, done}, 4'b0011);
        step();
        chk($sformatf("v%0d_idle", idx), {I, S, busy, done}, 4'b0000);
        if (!hold) begin
            step();
            chk($sformatf("v%0d_noextra", idx), {I, S, busy, done}, 4'b0000);
        end
    endtask

    initial begin
        vecs[0] = '{d: 8'hA5, seq: 8'b10100101, par: 1'b0, inj: -1, hold: 1'b0};
        vecs[1] = '{d: 8'h07, seq: 8'b11100000, par: 1'b1, inj: -1, hold: 1'b0};
        vecs[2] = '{d: 8'hFF, seq: 8'b11111111, par: 1'b0, inj: -1, hold: 1'b1};
        vecs[3] = '{d: 8'h00, seq: 8'b00000000, par: 1'b0, inj: -1, hold: 1'b0};
        vecs[4] = '{d: 8'h5A, seq: 8'b01011010, par: 1'b0, inj: 3,  hold: 1'b0};
        vecs[5] = '{d: 8'h01, seq: 8'b10000000, par: 1'b1, inj: -1, hold: 1'b0};

        reset = 1'b1;
        load  = 1'b0;
        data  = 8'h00;
        load2 = 1'b0;
        data2 = 2'b00;
        #1;
        chk("reset_w8", {I, S, busy, done}, 4'b0000);
        chk("reset_w2", {I2, S2, busy2, done2}, 4'b0000);
        step();
        reset = 1'b0;

        // First edge after reset release must accept the load
        for (int v = 0; v < 6; v++)
            send_frame(v, vecs[v].d, vecs[v].seq, vecs[v].par, vecs[v].inj, vecs[v].hold);

        // Asynchronous reset in the middle of bit 5
        load = 1'b1;
        data = 8'hA5;
        step();
        load = 1'b0;
        repeat (5) step();
        chk("rst_bit5", {I, S, busy, done}, 4'b1010);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", {I, S, busy, done}, 4'b0000);
        step();
        chk("rst_held", {I, S, busy, done}, 4'b0000);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_quiet%0d", k), {I, S, busy, done}, 4'b0000);
        end
        send_frame(6, 8'h3C, 8'b00111100, 1'b0, -1, 1'b0);

        // WIDTH=2 instance, data=2'b10
        load2 = 1'b1;
        data2 = 2'b10;
        step();
        load2 = 1'b0;
        data2 = 2'b01;
        chk("w2_bit0", {I2, S2, busy2, done2}, 4'b0110);
        step();
        chk("w2_bit1", {I2, S2, busy2, done2}, 4'b1010);
        step();
`ifdef SERIAL_FRAME_TX_PARITY_EN
        chk("w2_parity", {I2, S2, busy2, done2}, 4'b1010);
        step();
`endif
        chk("w2_done", {I2, S2, busy2, done2}, 4'b0011);
        step();
        chk("w2_idle", {I2, S2, busy2, done2}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
